// File: rtl/multicycle_adder_if.sv
// Operand/result bundle between an ALU sequencer and the multi-cycle adder.
// The master issues operands and start; the slave returns status and result.
interface multicycle_adder_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             Ofl;

  modport master (
    output start, sub, A, B, Cin,
    input  busy, done, S, Cout, Ofl
  );

  modport slave (
    input  start, sub, A, B, Cin,
    output busy, done, S, Cout, Ofl
  );
endinterface

// File: rtl/multicycle_adder.sv
// Multi-cycle ripple adder/subtractor: CHUNK bits per clock, LSB chunk first,
// with the inter-chunk carry held in a register. Start/busy/done handshake.
module multicycle_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic               clk,
  input  logic               rst,
  multicycle_adder_if.slave  bus
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             carry, carry_n;
  logic [WIDTH-1:0] op_a, op_a_n;
  logic [WIDTH-1:0] op_b, op_b_n;
  logic [WIDTH-1:0] s_q, s_n;
  logic             cout_q, cout_n;
  logic             ofl_q, ofl_n;
  logic             busy_q, busy_n;
  logic             done_q, done_n;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   chunk_sum;
  logic             msb_carry_in;
  logic             last_chunk;

  // Select the operand chunk addressed by the counter and ripple it through.
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int unsigned k = 0; k < NCHUNK; k++) begin
      if (cnt == CNT_W'(k)) begin
        a_chunk = op_a[k*CHUNK +: CHUNK];
        b_chunk = op_b[k*CHUNK +: CHUNK];
      end
    end
    chunk_sum    = {1'b0, a_chunk} + {1'b0, b_chunk} + (CHUNK+1)'(carry);
    // Carry into the chunk's top bit recovered from that bit's sum equation.
    msb_carry_in = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_sum[CHUNK-1];
    last_chunk   = (cnt == CNT_W'(NCHUNK - 1));
  end

  // Next-state and datapath update.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    carry_n = carry;
    op_a_n  = op_a;
    op_b_n  = op_b;
    s_n     = s_q;
    cout_n  = cout_q;
    ofl_n   = ofl_q;

    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          op_a_n  = bus.A;
          op_b_n  = bus.B ^ {WIDTH{bus.sub}};
          carry_n = bus.sub ? 1'b1 : bus.Cin;
          s_n     = '0;
          cnt_n   = '0;
          state_n = RUN;
        end else begin
          state_n = IDLE;
        end
      end
      RUN: begin
        for (int unsigned k = 0; k < NCHUNK; k++) begin
          if (cnt == CNT_W'(k)) begin
            s_n[k*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
          end
        end
        carry_n = chunk_sum[CHUNK];
        if (last_chunk) begin
          cout_n  = chunk_sum[CHUNK];
          ofl_n   = msb_carry_in ^ chunk_sum[CHUNK];
          state_n = DONE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n == RUN);
    done_n = (state_n == DONE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      carry  <= 1'b0;
      op_a   <= '0;
      op_b   <= '0;
      s_q    <= '0;
      cout_q <= 1'b0;
      ofl_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      carry  <= carry_n;
      op_a   <= op_a_n;
      op_b   <= op_b_n;
      s_q    <= s_n;
      cout_q <= cout_n;
      ofl_q  <= ofl_n;
      busy_q <= busy_n;
      done_q <= done_n;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.S    = s_q;
  assign bus.Cout = cout_q;
  assign bus.Ofl  = ofl_q;

endmodule

// File: tb/tb_multicycle_adder.sv
// Scoreboarded bench for multicycle_adder: directed handshake/reset cases plus
// randomized operations against a signed/unsigned arithmetic reference model.
module tb_multicycle_adder;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned CHUNK  = 4;
  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int          BUDGET = 100;

  localparam longint SMAX = (longint'(1) << (WIDTH - 1)) - 1;
  localparam longint SMIN = -(longint'(1) << (WIDTH - 1));
  localparam longint UMOD = longint'(1) << WIDTH;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ofl;
  } exp_t;

  logic clk;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];
  logic prev_done;

  multicycle_adder_if #(.WIDTH(WIDTH)) bus ();

  multicycle_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Reference: plain integer arithmetic on the unsigned and signed views.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin, input logic sub);
    exp_t   m;
    longint ua, ub, sa, sb, full, sres;
    logic [63:0] fbits;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sub) begin
      full   = ua - ub;
      m.cout = (ua >= ub);
      sres   = sa - sb;
    end else begin
      full   = ua + ub + longint'(cin);
      m.cout = (full >= UMOD);
      sres   = sa + sb + longint'(cin);
    end
    fbits = 64'(full);
    m.s   = fbits[WIDTH-1:0];
    m.ofl = (sres > SMAX) || (sres < SMIN);
    return m;
  endfunction

  // Monitor: every done pulse pops one expectation; done must never last two cycles.
  always @(negedge clk) begin
    if (rst) begin
      prev_done = 1'b0;
    end else begin
      if (bus.done) begin
        check("done_width", 64'(prev_done), 64'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("S", 64'(bus.S), 64'(e.s));
          check("Cout", 64'(bus.Cout), 64'(e.cout));
          check("Ofl", 64'(bus.Ofl), 64'(e.ofl));
        end
      end
      prev_done = bus.done;
    end
  end

  task automatic wait_idle();
    int cyc = 0;
    while (bus.busy && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
    end
    if (bus.busy) check("idle_timeout", 64'd1, 64'd0);
  endtask

  // Issue one op, scramble inputs during RUN, and check busy length and latency.
  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic cin, input logic sub, input exp_t e,
                       input bit check_lat);
    int cyc;
    int busy_cnt;
    wait_idle();
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    bus.Cin   = cin;
    bus.sub   = sub;
    exp_q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    bus.A     = WIDTH'($urandom);
    bus.B     = WIDTH'($urandom);
    bus.Cin   = 1'($urandom);
    bus.sub   = 1'($urandom);
    cyc       = 1;
    busy_cnt  = 0;
    while (!bus.done && cyc < BUDGET) begin
      if (bus.busy) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
    if (!bus.done) begin
      check("done_timeout", 64'd1, 64'd0);
    end else if (check_lat) begin
      check("latency", 64'(cyc), 64'(NCHUNK + 1));
      check("busy_cycles", 64'(busy_cnt), 64'(NCHUNK));
    end
  endtask

  initial begin
    exp_t e;
    int   cyc;
    logic [WIDTH-1:0] ra, rb;
    logic rc, rs;
    int   gap;

    rst       = 1'b1;
    prev_done = 1'b0;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.Cin   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_S", 64'(bus.S), 64'd0);
    check("rst_Cout", 64'(bus.Cout), 64'd0);
    check("rst_Ofl", 64'(bus.Ofl), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed arithmetic cases with hand-computed results.
    e = '{s: 16'h2202, cout: 1'b0, ofl: 1'b0};
    do_op(16'h1234, 16'h0FCD, 1'b1, 1'b0, e, 1'b1);
    e = '{s: 16'h0000, cout: 1'b1, ofl: 1'b0};
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, e, 1'b1);
    e = '{s: 16'h7FFF, cout: 1'b1, ofl: 1'b1};
    do_op(16'h8000, 16'h0001, 1'b1, 1'b1, e, 1'b1);
    e = '{s: 16'hFFFE, cout: 1'b0, ofl: 1'b0};
    do_op(16'h0003, 16'h0005, 1'b0, 1'b1, e, 1'b1);

    // Start held through RUN, with new operands presented; accepted only in DONE.
    wait_idle();
    bus.start = 1'b1;
    bus.A = 16'h00FF; bus.B = 16'h0F01; bus.Cin = 1'b0; bus.sub = 1'b0;
    exp_q.push_back('{s: 16'h1000, cout: 1'b0, ofl: 1'b0});
    @(negedge clk);
    bus.A = 16'h0000; bus.B = 16'h0001; bus.Cin = 1'b1; bus.sub = 1'b1;
    exp_q.push_back('{s: 16'hFFFF, cout: 1'b0, ofl: 1'b0});
    cyc = 1;
    while (!bus.done && cyc < BUDGET) begin @(negedge clk); cyc++; end
    check("hold_first_done", 64'(bus.done), 64'd1);
    @(negedge clk);
    check("b2b_busy", 64'(bus.busy), 64'd1);
    check("b2b_done_low", 64'(bus.done), 64'd0);
    bus.start = 1'b0;
    cyc = 0;
    while (!bus.done && cyc < BUDGET) begin @(negedge clk); cyc++; end
    check("b2b_second_done", 64'(bus.done), 64'd1);

    // Reset in the second RUN cycle: outputs clear at once, no done pulse follows.
    wait_idle();
    bus.start = 1'b1;
    bus.A = 16'h1111; bus.B = 16'h2222; bus.Cin = 1'b0; bus.sub = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("pre_rst_busy", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 64'(bus.busy), 64'd0);
    check("mid_rst_done", 64'(bus.done), 64'd0);
    check("mid_rst_S", 64'(bus.S), 64'd0);
    check("mid_rst_Cout", 64'(bus.Cout), 64'd0);
    check("mid_rst_Ofl", 64'(bus.Ofl), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (NCHUNK + 2) @(negedge clk);
    e = '{s: 16'h0002, cout: 1'b0, ofl: 1'b0};
    do_op(16'h0001, 16'h0001, 1'b0, 1'b0, e, 1'b1);

    // Randomized operations, mixing back-to-back starts and idle gaps.
    for (int i = 0; i < 1000; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      if (i % 10 == 0) ra = (i % 20 == 0) ? {WIDTH{1'b1}} : {1'b1, {(WIDTH-1){1'b0}}};
      e = model(ra, rb, rc, rs);
      do_op(ra, rb, rc, rs, e, (i % 50 == 0));
      gap = int'($urandom_range(0, 2));
      if (gap > 0) begin
        repeat (gap) @(negedge clk);
        check("S_held", 64'(bus.S), 64'(e.s));
      end
    end

    cyc = 0;
    while (exp_q.size() != 0 && cyc < BUDGET) begin @(negedge clk); cyc++; end
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
